// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX frame decoder and the TX serializer.
package uart_pkg;

  // Frame-level states of the receiver (the TX side reuses the same names).
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_t;

  // Parity type selector values.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Supported oversampling ratios.
  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // True for an oversampling ratio the bit timing is designed around.
  function automatic logic legal_prescale(input int p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

  // 2-of-3 vote used to reject single-sample noise inside a bit.
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Line, configuration and result bundle of the UART frame receiver.
interface uart_rx_frame_if #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] PRESCALE;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_W-1:0]     P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_ERR;
  logic                  STP_ERR;

  // Side that owns the serial line and configuration and consumes bytes.
  modport master (
    output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

  // Receiver side.
  modport slave (
    input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority voter around the bit centre.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  run,       // a frame is in progress
  input  logic                  start,     // start edge seen this cycle (edge 0)
  input  logic                  rx_s,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_val,
  output logic                  bit_done
);

  logic [PRESCALE_W-1:0] edge_cnt_reg;
  logic [2:0]            samples_reg;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last_edge;

  assign half      = prescale >> 1;
  assign last_edge = prescale - PRESCALE_W'(1);

  // Edge counter: the start-detect cycle is edge 0, so the first counted value is 1.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      edge_cnt_reg <= '0;
    end else if (run) begin
      edge_cnt_reg <= (edge_cnt_reg == last_edge) ? '0 : edge_cnt_reg + PRESCALE_W'(1);
    end else begin
      edge_cnt_reg <= start ? PRESCALE_W'(1) : '0;
    end
  end

  // Capture the three centre samples of the current bit.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      samples_reg <= 3'b111;
    end else if (run) begin
      if (edge_cnt_reg == half - PRESCALE_W'(1)) samples_reg[0] <= rx_s;
      if (edge_cnt_reg == half)                  samples_reg[1] <= rx_s;
      if (edge_cnt_reg == half + PRESCALE_W'(1)) samples_reg[2] <= rx_s;
    end
  end

  assign bit_val  = majority3(samples_reg);
  assign bit_done = run && (edge_cnt_reg == last_edge);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: synchronizer, frame FSM, shift register and parity/stop checks.
module uart_rx_frame #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input logic           CLK,
  input logic           RST,
  uart_rx_frame_if.slave bus
);
  import uart_pkg::*;

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [1:0]            sync_reg;
  logic                  rx_s;
  uart_state_t           state_reg;
  logic [CNT_W-1:0]      bit_cnt_reg;
  logic [DATA_W-1:0]     shift_reg;
  logic                  par_bad_reg;
  logic [PRESCALE_W-1:0] prescale_reg;
  logic                  par_en_reg;
  logic                  par_typ_reg;
  logic [DATA_W-1:0]     p_data_reg;
  logic                  data_valid_reg;
  logic                  par_err_reg;
  logic                  stp_err_reg;
  logic                  run;
  logic                  start;
  logic                  bit_val;
  logic                  bit_done;
  logic                  exp_par;

  assign rx_s    = sync_reg[1];
  assign run     = (state_reg == START) || (state_reg == DATA) ||
                   (state_reg == PARITY) || (state_reg == STOP);
  assign start   = (state_reg == IDLE) && !rx_s;
  assign exp_par = (^shift_reg) ^ (par_typ_reg == PAR_ODD);

  // Two-flop synchronizer for the asynchronous line; resets to the idle level.
  always_ff @(posedge CLK) begin
    if (!RST) sync_reg <= 2'b11;
    else      sync_reg <= {sync_reg[0], bus.RX_IN};
  end

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .CLK      (CLK),
    .RST      (RST),
    .run      (run),
    .start    (start),
    .rx_s     (rx_s),
    .prescale (prescale_reg),
    .bit_val  (bit_val),
    .bit_done (bit_done)
  );

  // Frame FSM with registered byte, strobe and error flags.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      par_bad_reg    <= 1'b0;
      prescale_reg   <= PRESCALE_W'(PRESCALE_8);
      par_en_reg     <= 1'b0;
      par_typ_reg    <= PAR_EVEN;
      p_data_reg     <= '0;
      data_valid_reg <= 1'b0;
      par_err_reg    <= 1'b0;
      stp_err_reg    <= 1'b0;
    end else begin
      data_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            // Configuration is frozen for the whole frame; an unsupported
            // ratio falls back to 16 so the counters stay well defined.
            state_reg    <= START;
            prescale_reg <= legal_prescale(int'(bus.PRESCALE)) ?
                            bus.PRESCALE : PRESCALE_W'(PRESCALE_16);
            par_en_reg   <= bus.PAR_EN;
            par_typ_reg  <= bus.PAR_TYP;
          end
        end
        START: begin
          if (bit_done) begin
            if (!bit_val) begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
              par_bad_reg <= 1'b0;
              par_err_reg <= 1'b0;
              stp_err_reg <= 1'b0;
            end else begin
              state_reg <= IDLE;  // glitch, flags untouched
            end
          end
        end
        DATA: begin
          if (bit_done) begin
            shift_reg <= {bit_val, shift_reg[DATA_W-1:1]};
            if (bit_cnt_reg == LAST_BIT) begin
              state_reg <= par_en_reg ? PARITY : STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            if (bit_val != exp_par) par_bad_reg <= 1'b1;
            state_reg <= STOP;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (bit_val) begin
              if (par_bad_reg) begin
                par_err_reg <= 1'b1;
              end else begin
                p_data_reg     <= shift_reg;
                data_valid_reg <= 1'b1;
              end
              state_reg <= IDLE;
            end else begin
              stp_err_reg <= 1'b1;
              par_err_reg <= par_bad_reg;
              state_reg   <= BREAK;
            end
          end
        end
        BREAK: begin
          // A held-low line reports one framing error, then waits for idle.
          if (rx_s) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.P_DATA     = p_data_reg;
  assign bus.DATA_VALID = data_valid_reg;
  assign bus.PAR_ERR    = par_err_reg;
  assign bus.STP_ERR    = stp_err_reg;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame with a cycle-stamped result scoreboard.
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int DATA_W     = 8;
  localparam int PRESCALE_W = 6;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       dv;
    logic       pe;
    logic       se;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [7:0] last_good = 8'h00;
  logic       mon_en = 1'b0;
  logic       pe_prev = 1'b0;
  logic       se_prev = 1'b0;
  exp_t       sb[$];
  exp_t       got;

  always #5 clk = ~clk;

  // Cycle index used to stamp expected result times.
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_frame_if #(.DATA_W(DATA_W), .PRESCALE_W(PRESCALE_W)) bus ();

  uart_rx_frame #(.DATA_W(DATA_W), .PRESCALE_W(PRESCALE_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // kind: 0 = no result expected, 1 = good byte, 2 = parity error.
  task automatic send_frame(input logic [7:0] d, input int p, input bit pe,
                            input bit ptyp, input bit bad_par, input int kind,
                            input int rst_bit, input bit cfg_mid);
    int   n;
    logic par;
    exp_t e;
    n = 2 + DATA_W + (pe ? 1 : 0);
    if (kind == 1) begin
      e = '{cyc + 2 + n * p, d, 1'b1, 1'b0, 1'b0};
      last_good = d;
      sb.push_back(e);
    end else if (kind == 2) begin
      e = '{cyc + 2 + n * p, last_good, 1'b0, 1'b1, 1'b0};
      sb.push_back(e);
    end
    bus.RX_IN = 1'b0;
    tick(p);
    for (int i = 0; i < DATA_W; i++) begin
      bus.RX_IN = d[i];
      if (cfg_mid && i == 3) begin
        bus.PRESCALE = 6'd16;
        bus.PAR_EN   = 1'b1;
      end
      if (i == rst_bit) begin
        tick(p / 2);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        bus.RX_IN = 1'b1;
        last_good = 8'h00;
        return;
      end
      tick(p);
    end
    if (pe) begin
      par = (^d) ^ ptyp ^ bad_par;
      bus.RX_IN = par;
      tick(p);
    end
    bus.RX_IN = 1'b1;
    tick(p);
  endtask

  // Monitor: scheduled results are popped and compared; all other cycles must be quiet.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        got = sb.pop_front();
        $display("frame result cyc=%0d dv=%b p_data=%h par_err=%b stp_err=%b",
                 cyc, bus.DATA_VALID, bus.P_DATA, bus.PAR_ERR, bus.STP_ERR);
        check("data_valid", {31'b0, bus.DATA_VALID}, {31'b0, got.dv});
        check("p_data", {24'b0, bus.P_DATA}, {24'b0, got.data});
        check("par_err", {31'b0, bus.PAR_ERR}, {31'b0, got.pe});
        check("stp_err", {31'b0, bus.STP_ERR}, {31'b0, got.se});
      end else begin
        check("quiet", {29'b0, bus.DATA_VALID, bus.PAR_ERR & ~pe_prev, bus.STP_ERR & ~se_prev},
              32'd0);
      end
    end
    pe_prev = bus.PAR_ERR;
    se_prev = bus.STP_ERR;
  end

  initial begin
    exp_t e;
    bus.RX_IN    = 1'b1;
    bus.PRESCALE = 6'd8;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    @(negedge clk);
    check("rst_p_data", {24'b0, bus.P_DATA}, 32'h0);
    check("rst_dv", {31'b0, bus.DATA_VALID}, 32'h0);
    check("rst_par_err", {31'b0, bus.PAR_ERR}, 32'h0);
    check("rst_stp_err", {31'b0, bus.STP_ERR}, 32'h0);
    mon_en = 1'b1;
    tick(1);

    // Short low glitch: no strobe, no flags.
    bus.RX_IN = 1'b0;
    tick(3);
    bus.RX_IN = 1'b1;
    tick(30);
    @(negedge clk);
    check("glitch_par_err", {31'b0, bus.PAR_ERR}, 32'h0);
    check("glitch_stp_err", {31'b0, bus.STP_ERR}, 32'h0);
    check("glitch_p_data", {24'b0, bus.P_DATA}, 32'h0);
    tick(1);

    // Line held low for 200 cycles: exactly one framing error.
    e = '{cyc + 2 + 10 * 8, last_good, 1'b0, 1'b0, 1'b1};
    sb.push_back(e);
    bus.RX_IN = 1'b0;
    tick(200);
    bus.RX_IN = 1'b1;
    tick(20);
    @(negedge clk);
    check("break_stp_held", {31'b0, bus.STP_ERR}, 32'h1);
    tick(1);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1, -1, 1'b0);
    tick(10);

    // Good frame, no parity.
    send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b0, 1, -1, 1'b0);
    tick(10);

    // Back-to-back even-parity frames.
    bus.PRESCALE = 6'd16;
    bus.PAR_EN   = 1'b1;
    bus.PAR_TYP  = PAR_EVEN;
    send_frame(8'hBB, 16, 1'b1, 1'b0, 1'b0, 1, -1, 1'b0);
    send_frame(8'h0C, 16, 1'b1, 1'b0, 1'b0, 1, -1, 1'b0);
    send_frame(8'hDD, 16, 1'b1, 1'b0, 1'b0, 1, -1, 1'b0);
    tick(20);

    // Odd parity: wrong parity bit, then a good frame.
    bus.PRESCALE = 6'd32;
    bus.PAR_TYP  = PAR_ODD;
    send_frame(8'h35, 32, 1'b1, 1'b1, 1'b1, 2, -1, 1'b0);
    tick(10);
    @(negedge clk);
    check("parerr_held", {31'b0, bus.PAR_ERR}, 32'h1);
    tick(1);
    send_frame(8'h01, 32, 1'b1, 1'b1, 1'b0, 1, -1, 1'b0);
    tick(10);

    // Reset during bit 4, then the same byte again.
    bus.PRESCALE = 6'd8;
    bus.PAR_EN   = 1'b0;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 0, 4, 1'b0);
    @(negedge clk);
    check("mid_rst_p_data", {24'b0, bus.P_DATA}, 32'h0);
    check("mid_rst_dv", {31'b0, bus.DATA_VALID}, 32'h0);
    check("mid_rst_par_err", {31'b0, bus.PAR_ERR}, 32'h0);
    check("mid_rst_stp_err", {31'b0, bus.STP_ERR}, 32'h0);
    tick(1);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1, -1, 1'b0);
    tick(10);

    // Configuration change mid-frame applies to the next frame only.
    bus.PRESCALE = 6'd8;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = PAR_EVEN;
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1, -1, 1'b1);
    tick(10);
    send_frame(8'h34, 16, 1'b1, 1'b0, 1'b0, 1, -1, 1'b0);
    tick(40);

    @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial UART receiver that turns the asynchronous RX line into one parallel byte per frame with a single-cycle valid strobe. Its byte and strobe feed the RX data synchronizer that delivers the command stream to the system controller (0xAA/0xBB/0xCC/0xDD opcodes, addresses, operands). It runs in the oversampled RX clock domain and supports configurable oversampling, optional parity, and per-frame error flags.

## Interface
- DATA_W, 8, data bits per frame (LSB first)
- PRESCALE_W, 6, width of the oversampling ratio input
- CLK  in  1  RX oversampling clock; all logic on rising edge
- RST  in  1  reset; synchronous, active-low
- RX_IN  in  1  asynchronous serial line, idle high
- PRESCALE  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
- PAR_EN  in  1  1 = parity bit present
- PAR_TYP  in  1  0 = even, 1 = odd
- P_DATA  out  DATA_W  last good byte; held until the next good frame
- DATA_VALID  out  1  one-cycle pulse per good frame
- PAR_ERR  out  1  parity mismatch on the last frame; held
- STP_ERR  out  1  stop bit sampled low on the last frame; held

## Operation
- RX_IN passes through a 2-flop synchronizer (reset value 1). All logic below uses the synchronized line `rx_s`.
- edge_cnt counts 0..PRESCALE-1 within each bit. bit_cnt indexes the data bits.
- Bit value = majority of `rx_s` at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1. The decision is available at edge_cnt = PRESCALE/2+2.
- PRESCALE, PAR_EN and PAR_TYP are latched when the start bit is detected. Changes mid-frame have no effect.
- States:
  - IDLE: when `rx_s`=0, go to START. That cycle counts as edge 0.
  - START: at edge PRESCALE-1, go to DATA if the voted bit is 0. Otherwise it is a glitch: return to IDLE with no flag change.
  - DATA: shift the voted bit in LSB first. After DATA_W bits, go to PARITY if PAR_EN=1, else to STOP.
  - PARITY: compare the voted bit with the XOR of the data bits, inverted when PAR_TYP=1. A mismatch sets the internal par_bad flag.
  - STOP: at edge PRESCALE-1:
    - voted 1 and no par_bad: load P_DATA, pulse DATA_VALID, go to IDLE.
    - voted 1 with par_bad: PAR_ERR=1, no DATA_VALID, P_DATA unchanged, go to IDLE.
    - voted 0: STP_ERR=1 (PAR_ERR also set if par_bad), no DATA_VALID, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. A held-low line therefore produces exactly one STP_ERR frame, not a repeating stream.
- PAR_ERR and STP_ERR clear when the next start bit is accepted (START→DATA).
- PRESCALE values outside 8/16/32 are unsupported. The bench does not drive them.

## Timing
- Reset (RST=0 at a rising edge) values:
  - P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0.
  - State IDLE, counters 0, synchronizer flops 1.
- Reset mid-frame abandons the frame with no strobe. The next frame is accepted normally.
- Frame length N = 1+DATA_W+PAR_EN+1 bits. Let T be the first cycle with `rx_s`=0.
  - DATA_VALID and the error flags are registered and appear in cycle T+N×PRESCALE.
  - `rx_s` lags RX_IN by 2 cycles.
- DATA_VALID is high for exactly 1 cycle. P_DATA is stable from that cycle until the next good frame.
- Back-to-back frames: a start edge arriving in the first IDLE cycle after STOP is accepted with no lost cycle.
- DATA_VALID and an error flag are never set for the same frame.

## Structure
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, BREAK).
  - PAR_EVEN/PAR_ODD constants.
  - legal PRESCALE constants 8/16/32.
  - This package is also used by the TX serializer.
- Sub-module uart_rx_sampler contains the edge counter and the 3-sample majority voter. It outputs `bit_val` and `bit_done` (high at edge PRESCALE-1).
- The FSM, shift register, parity check and synchronizer stay in uart_rx_frame.

## Test plan
- Good frame, no parity: PRESCALE=8, PAR_EN=0, byte 0xAA. Expect:
  - exactly one DATA_VALID pulse with P_DATA=0xAA.
  - the pulse lands 80 cycles after `rx_s` falls.
  - PAR_ERR=STP_ERR=0.
- Back-to-back parity frames: PRESCALE=16, PAR_EN=1, PAR_TYP=0, frames 0xBB, 0x0C, 0xDD sent with no gap. Expect:
  - three pulses, 176 cycles apart.
  - P_DATA = 0xBB, 0x0C, 0xDD in order.
- Parity error: PRESCALE=32, PAR_TYP=1, byte 0x35 sent with wrong parity bit. Expect:
  - PAR_ERR=1 and no DATA_VALID.
  - P_DATA keeps its previous value.
  - the next good frame 0x01 clears PAR_ERR and strobes 0x01.
- Glitch and break:
  - a 3-cycle low glitch on RX_IN at PRESCALE=8 gives no flags and no strobe.
  - RX_IN held low for 200 cycles gives exactly one STP_ERR with P_DATA=0x00 not strobed.
  - the next frame is received after the line returns high.
- Reset mid-frame: assert RST=0 for 1 cycle during bit 4 of 0x5A. Expect:
  - all outputs 0 with no strobe.
  - the following frame 0x5A strobes correctly.
- Config change mid-frame: change PRESCALE 8→16 and PAR_EN 0→1 during a frame. Expect:
  - the current frame is decoded with the old settings.
  - the next frame is decoded with the new ones.
